// File: rtl/fb_scanout.sv
// Framebuffer scanout engine: streams one dmem word per pixel into a small FIFO
// ahead of the VGA consumer, restarting from FB_BASE on every frame_start.
module fb_scanout #(
  parameter logic [31:0] FB_BASE    = 32'h0000_0400,
  parameter int          H_PIX      = 640,
  parameter int          V_PIX      = 480,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        px_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [23:0] px_rgb,
  output logic        px_valid,
  output logic        underrun
);
  localparam int NPIX = H_PIX * V_PIX;
  localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_PIX = CW'(NPIX - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] pix_q, pix_d;
  logic          inflight_q, inflight_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          underrun_q, underrun_d;
  logic [23:0]   fifo_q [FIFO_DEPTH];

  logic          issue, push, pop;
  logic [PW+1:0] occ;
  logic          unused_hi;

  assign unused_hi = ^mem_rdata[31:24];
  assign occ       = {1'b0, cnt_q} + (PW+2)'(inflight_q);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pix_d      = pix_q;
    inflight_d = 1'b0;
    wr_d       = wr_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    underrun_d = underrun_q | (px_req & ~px_valid);
    issue      = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    if (frame_start) begin
      // Restart wins over everything: flush, drop the returning datum, rewind.
      state_d = FETCH;
      addr_d  = FB_BASE;
      pix_d   = '0;
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
    end else begin
      issue = (state_q == FETCH) && (occ < (PW+2)'(FIFO_DEPTH));
      push  = inflight_q;
      pop   = px_req && px_valid;
      if (issue) begin
        addr_d     = addr_q + 32'd4;
        pix_d      = pix_q + CW'(1);
        inflight_d = 1'b1;
        if (pix_q == LAST_PIX) state_d = DONE;
      end
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + (PW+1)'(1);
        2'b01:   cnt_d = cnt_q - (PW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= FB_BASE;
      pix_q      <= '0;
      inflight_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pix_q      <= pix_d;
      inflight_q <= inflight_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      underrun_q <= underrun_d;
    end
  end

  // Storage needs no reset; px_rgb is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_q] <= mem_rdata[23:0];
  end

  assign mem_addr = addr_q;
  assign px_valid = (cnt_q != '0);
  assign px_rgb   = px_valid ? fifo_q[rd_q] : 24'h000000;
  assign underrun = underrun_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && cnt_q == (PW+1)'(FIFO_DEPTH)));

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout: each frame_start queues the whole frame's
// expected pixel stream; a negedge monitor checks every pop and address move.
module tb_fb_scanout;
  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam int H = 8, V = 4, NPIX = H * V;

  logic        clk = 1'b0, rst_n = 1'b0, fs = 1'b0, req = 1'b0;
  logic [31:0] maddr, rdata = '0;
  logic [23:0] rgb, seed = '0;
  logic        pv, urun;

  logic        s_fs = 1'b0, s_req = 1'b0;
  logic [31:0] s_addr, s_rdata = '0;
  logic [23:0] s_rgb;
  logic        s_pv, s_urun;

  int          n_chk = 0, n_pass = 0;
  logic [23:0] exp_q[$];
  logic [23:0] s_pops[$];
  int          s_reads = 0;

  fb_scanout #(.FB_BASE(BASE), .H_PIX(H), .V_PIX(V), .FIFO_DEPTH(8)) u_dut (
    .clk(clk), .reset(rst_n), .frame_start(fs), .px_req(req),
    .mem_addr(maddr), .mem_rdata(rdata), .px_rgb(rgb), .px_valid(pv), .underrun(urun));

  fb_scanout #(.FB_BASE(BASE), .H_PIX(4), .V_PIX(2), .FIFO_DEPTH(8)) u_small (
    .clk(clk), .reset(rst_n), .frame_start(s_fs), .px_req(s_req),
    .mem_addr(s_addr), .mem_rdata(s_rdata), .px_rgb(s_rgb), .px_valid(s_pv), .underrun(s_urun));

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a, input logic [23:0] s);
    return {8'hA5, a[23:0] ^ s};
  endfunction

  // dmem model: one-cycle registered read of whatever address is presented
  always @(posedge clk) begin
    rdata   <= word(maddr, seed);
    s_rdata <= s_addr;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [23:0] s);
    logic [31:0] w;
    fs   = 1'b1;
    seed = s;
    exp_q.delete();
    for (int i = 0; i < NPIX; i++) begin
      w = word(BASE + 32'(4 * i), s);
      exp_q.push_back(w[23:0]);
    end
    tick();
    fs = 1'b0;
  endtask

  task automatic drain(input int budget, input int rate);
    int idle;
    idle = 0;
    for (int c = 0; c < budget && idle < 4; c++) begin
      req = pv && ($urandom_range(99) < rate);
      tick();
      idle = (exp_q.size() == 0 && !pv) ? idle + 1 : 0;
    end
    req = 1'b0;
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pops against the scoreboard, address only holds/steps/rewinds
  logic        prev_fs = 1'b0;
  logic [31:0] prev_addr = BASE;
  logic [31:0] s_prev = BASE;
  always @(negedge clk) begin
    if (rst_n && !pv) chk("rgb_empty_zero", 32'(rgb), 32'd0);
    if (!rst_n) chk("addr_reset", maddr, BASE);
    else if (prev_fs) chk("addr_restart", maddr, BASE);
    else if (maddr !== prev_addr) chk("addr_step", maddr, prev_addr + 32'd4);
    if (rst_n && !fs && req && pv) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL pop_extra: got %h expected no pixel", rgb);
      end else chk("pixel", 32'(rgb), 32'(exp_q.pop_front()));
    end
    prev_fs   = fs && rst_n;
    prev_addr = maddr;
    if (s_req && s_pv) s_pops.push_back(s_rgb);
    if (s_addr !== s_prev) s_reads++;
    s_prev = s_addr;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [23:0] s1;
    repeat (2) tick();
    chk("rst_addr", maddr, BASE);
    chk("rst_valid", 32'(pv), 32'd0);
    chk("rst_rgb", 32'(rgb), 32'd0);
    chk("rst_underrun", 32'(urun), 32'd0);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_addr", maddr, BASE);
    chk("idle_valid", 32'(pv), 32'd0);

    // Fill with no consumer: eight reads, then stall
    start_frame('0);
    repeat (20) tick();
    chk("fill_stall_addr", maddr, BASE + 32'd32);
    chk("fill_valid", 32'(pv), 32'd1);
    chk("fill_head", 32'(rgb), 32'h0000_0400);
    repeat (5) tick();
    chk("fill_hold_addr", maddr, BASE + 32'd32);

    // Continuous consumption: one read per cycle after a two-cycle bubble
    req = 1'b1;
    tick();
    tick();
    a = maddr;
    chk("stream_first", a, BASE + 32'd36);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("stream_step", maddr, a + 32'(4 * (k + 1)));
    end
    chk("stream_underrun", 32'(urun), 32'd0);
    req = 1'b0;
    drain(300, 100);
    chk("frame_end_addr", maddr, BASE + 32'(4 * NPIX));
    repeat (5) tick();
    chk("done_hold_addr", maddr, BASE + 32'(4 * NPIX));
    chk("done_valid", 32'(pv), 32'd0);

    // Restart with FIFO half full and one read in flight
    s1 = 24'($urandom);
    start_frame(s1);
    repeat (5) tick();
    start_frame(s1 ^ 24'h5A5A5A);
    chk("flush_valid", 32'(pv), 32'd0);
    chk("flush_addr", maddr, BASE);
    drain(400, 60);

    // Randomized frames, some aborted mid-way by a new frame_start
    for (int f = 0; f < 6; f++) begin
      start_frame(24'($urandom));
      if ($urandom_range(1) == 0) begin
        repeat ($urandom_range(25, 3)) begin
          req = pv && ($urandom_range(1) == 1);
          tick();
        end
        req = 1'b0;
        start_frame(24'($urandom));
      end
      drain(600, $urandom_range(100, 30));
      chk("rand_frame_end", maddr, BASE + 32'(4 * NPIX));
      chk("rand_underrun", 32'(urun), 32'd0);
    end

    // Underrun on empty FIFO, sticky across frames
    start_frame(24'($urandom));
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("underrun_set", 32'(urun), 32'd1);
    start_frame(24'($urandom));
    repeat (3) tick();
    chk("underrun_sticky", 32'(urun), 32'd1);

    // Asynchronous reset mid-FETCH
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_addr", maddr, BASE);
    chk("async_valid", 32'(pv), 32'd0);
    chk("async_rgb", 32'(rgb), 32'd0);
    chk("async_underrun", 32'(urun), 32'd0);
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("post_reset_addr", maddr, BASE);
    chk("post_reset_valid", 32'(pv), 32'd0);

    // Small 4x2 frame drained completely
    s_fs = 1'b1;
    tick();
    s_fs = 1'b0;
    for (int c = 0; c < 40; c++) begin
      s_req = s_pv;
      tick();
    end
    s_req = 1'b0;
    chk("small_reads", 32'(s_reads), 32'd8);
    chk("small_addr", s_addr, BASE + 32'd32);
    chk("small_pops", 32'(s_pops.size()), 32'd8);
    for (int i = 0; i < s_pops.size() && i < 8; i++)
      chk("small_pixel", 32'(s_pops[i]), 32'(24'(BASE + 32'(4 * i))));
    repeat (5) tick();
    chk("small_done_addr", s_addr, BASE + 32'd32);
    chk("small_valid", 32'(s_pv), 32'd0);
    chk("small_underrun", 32'(s_urun), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
